// File: rtl/ram64_arbiter.sv
// rtl/ram64_arbiter.sv - round-robin two-requester arbiter/sequencer for a shared ram64 (optional clear sweep: CLEAR_ON_RESET_EN)
module ram64_arbiter #(
    parameter logic        RESET_PRIORITY = 1'b0,
    parameter logic [15:0] CLEAR_VALUE    = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        a_req,
    input  logic        a_we,
    input  logic [5:0]  a_addr,
    input  logic [15:0] a_wdata,
    output logic        a_gnt,
    output logic        a_ack,
    input  logic        b_req,
    input  logic        b_we,
    input  logic [5:0]  b_addr,
    input  logic [15:0] b_wdata,
    output logic        b_gnt,
    output logic        b_ack,
    output logic [15:0] rdata,
    output logic [15:0] mem_in,
    output logic [5:0]  mem_address,
    output logic        mem_load,
    input  logic [15:0] mem_out,
    output logic        busy
);

    logic        run;
    logic        clear_active;
    logic [5:0]  clr_cnt;

    logic        ptr;
    logic        iss_valid;
    logic        iss_we;
    logic [5:0]  iss_addr;
    logic [15:0] iss_wdata;
    logic        iss_id;

`ifdef CLEAR_ON_RESET_EN
    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t state;

    // Clear sweep sequencer: one word per cycle, hand over to RUN after address 63.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_CLEAR;
            clr_cnt <= 6'd0;
        end else if (state == ST_CLEAR) begin
            clr_cnt <= clr_cnt + 6'd1;
            if (clr_cnt == 6'd63) begin
                state <= ST_RUN;
            end
        end
    end

    // Gated by rst_n so no sweep write can be presented while reset is held.
    assign clear_active = rst_n && (state == ST_CLEAR);
    assign run          = (state == ST_RUN);
`else
    assign clear_active = 1'b0;
    assign clr_cnt      = 6'd0;
    assign run          = 1'b1;
`endif

    assign busy = clear_active;

    // Round-robin grant: a lone requester always wins, a tie goes to the pointer side.
    always_comb begin
        a_gnt = run && a_req && (!b_req || (ptr == 1'b0));
        b_gnt = run && b_req && (!a_req || (ptr == 1'b1));
    end

    // Issue register and priority pointer; pointer moves to the loser after each grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iss_valid <= 1'b0;
            iss_we    <= 1'b0;
            iss_addr  <= 6'd0;
            iss_wdata <= 16'h0000;
            iss_id    <= 1'b0;
            ptr       <= RESET_PRIORITY;
        end else begin
            iss_valid <= a_gnt || b_gnt;
            if (a_gnt) begin
                iss_we    <= a_we;
                iss_addr  <= a_addr;
                iss_wdata <= a_wdata;
                iss_id    <= 1'b0;
                ptr       <= 1'b1;
            end else if (b_gnt) begin
                iss_we    <= b_we;
                iss_addr  <= b_addr;
                iss_wdata <= b_wdata;
                iss_id    <= 1'b1;
                ptr       <= 1'b0;
            end
        end
    end

    // The sweep borrows the ram ports; otherwise they mirror the issue register.
    always_comb begin
        mem_address = clear_active ? clr_cnt : iss_addr;
        mem_in      = clear_active ? CLEAR_VALUE : iss_wdata;
        mem_load    = clear_active || (iss_valid && iss_we);
    end

    // Response stage: capture read (or pre-write) data and pulse the owner's ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_ack <= 1'b0;
            b_ack <= 1'b0;
            rdata <= 16'h0000;
        end else begin
            a_ack <= iss_valid && !iss_id;
            b_ack <= iss_valid && iss_id;
            if (iss_valid) begin
                rdata <= mem_out;
            end
        end
    end

endmodule

// File: tb/tb_ram64_arbiter.sv
// tb/tb_ram64_arbiter.sv - randomized self-checking bench for ram64_arbiter against a queue-based reference model
`timescale 1ns/1ps
module tb_ram64_arbiter;

    localparam logic RP = 1'b0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        a_req = 1'b0, a_we = 1'b0;
    logic [5:0]  a_addr = 6'd0;
    logic [15:0] a_wdata = 16'h0;
    logic        b_req = 1'b0, b_we = 1'b0;
    logic [5:0]  b_addr = 6'd0;
    logic [15:0] b_wdata = 16'h0;
    logic        a_gnt, a_ack, b_gnt, b_ack, mem_load, busy;
    logic [15:0] rdata, mem_in, mem_out;
    logic [5:0]  mem_address;

    always #5 clk = ~clk;

    ram64_arbiter #(.RESET_PRIORITY(RP), .CLEAR_VALUE(16'h0000)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_gnt(a_gnt), .a_ack(a_ack),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_gnt(b_gnt), .b_ack(b_ack),
        .rdata(rdata), .mem_in(mem_in), .mem_address(mem_address), .mem_load(mem_load),
        .mem_out(mem_out), .busy(busy)
    );

    // ram64 environment model: combinational read, write on posedge when load is high
    logic [15:0] ram [64];
    assign mem_out = ram[mem_address];
    always @(posedge clk) begin
        if (mem_load) ram[mem_address] <= mem_in;
    end

    typedef struct {
        int          iss;
        bit          id;
        bit          we;
        logic [5:0]  addr;
        logic [15:0] wdata;
        logic [15:0] rd;
    } txn_t;

    logic [15:0] ref_mem [64];
    txn_t        q[$];
    bit          m_ptr;
    int          clear_left;
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_err = 0;
    bit          a_g, b_g;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_ptr = RP;
`ifdef CLEAR_ON_RESET_EN
        clear_left = 64;
`else
        clear_left = 0;
`endif
        a_g = 1'b0;
        b_g = 1'b0;
    endtask

    // One clock cycle: check DUT at negedge against the model, then advance past posedge
    task automatic tick();
        bit   ea, eb, exp_load;
        txn_t t;
        @(negedge clk);
        chk("two_gnt", 32'(a_gnt & b_gnt), 32'd0);
        if (clear_left > 0) begin
            chk("clr_busy", 32'(busy), 32'd1);
            chk("clr_load", 32'(mem_load), 32'd1);
            chk("clr_addr", 32'(mem_address), 32'(64 - clear_left));
            chk("clr_in", 32'(mem_in), 32'd0);
            chk("clr_a_gnt", 32'(a_gnt), 32'd0);
            chk("clr_b_gnt", 32'(b_gnt), 32'd0);
            ref_mem[64 - clear_left] = 16'h0000;
            clear_left--;
            a_g = 1'b0;
            b_g = 1'b0;
        end else begin
            chk("busy", 32'(busy), 32'd0);
            ea = 1'b0;
            eb = 1'b0;
            if (q.size() > 0 && q[0].iss + 1 == cyc) begin
                t = q.pop_front();
                if (t.id) eb = 1'b1; else ea = 1'b1;
                chk("rdata", 32'(rdata), 32'(t.rd));
            end
            chk("a_ack", 32'(a_ack), 32'(ea));
            chk("b_ack", 32'(b_ack), 32'(eb));
            exp_load = 1'b0;
            if (q.size() > 0 && q[0].iss == cyc) begin
                t = q[0];
                t.rd = ref_mem[t.addr];
                chk("mem_address", 32'(mem_address), 32'(t.addr));
                if (t.we) begin
                    exp_load = 1'b1;
                    chk("mem_in", 32'(mem_in), 32'(t.wdata));
                    ref_mem[t.addr] = t.wdata;
                end
                q[0] = t;
            end
            chk("mem_load", 32'(mem_load), 32'(exp_load));
            ea = a_req && (!b_req || m_ptr == 1'b0);
            eb = b_req && (!a_req || m_ptr == 1'b1);
            chk("a_gnt", 32'(a_gnt), 32'(ea));
            chk("b_gnt", 32'(b_gnt), 32'(eb));
            if (ea) begin
                q.push_back('{cyc + 1, 1'b0, a_we, a_addr, a_wdata, 16'h0});
                m_ptr = 1'b1;
            end else if (eb) begin
                q.push_back('{cyc + 1, 1'b1, b_we, b_addr, b_wdata, 16'h0});
                m_ptr = 1'b0;
            end
            a_g = ea;
            b_g = eb;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic set_a(input bit req, input bit we, input logic [5:0] addr, input logic [15:0] wd);
        a_req = req; a_we = we; a_addr = addr; a_wdata = wd;
    endtask

    task automatic set_b(input bit req, input bit we, input logic [5:0] addr, input logic [15:0] wd);
        b_req = req; b_we = we; b_addr = addr; b_wdata = wd;
    endtask

    task automatic reset_check();
        @(negedge clk);
        chk("rst_a_ack", 32'(a_ack), 32'd0);
        chk("rst_b_ack", 32'(b_ack), 32'd0);
        chk("rst_rdata", 32'(rdata), 32'd0);
        chk("rst_load", 32'(mem_load), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        cyc++;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic run_clear();
        while (clear_left > 0) tick();
    endtask

    task automatic drain(input int n);
        set_a(1'b0, 1'b0, 6'd0, 16'h0);
        set_b(1'b0, 1'b0, 6'd0, 16'h0);
        repeat (n) tick();
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            ref_mem[i] = 16'($urandom);
            ram[i] = ref_mem[i];
        end
        model_reset();

        // power-on reset
        rst_n = 1'b0;
        reset_check();
        chk("rst_addr_after", 32'(mem_address), 32'd0);
        run_clear();

        // single writer: write then back-to-back read of the same word
        set_a(1'b1, 1'b1, 6'd5, 16'h1234);
        tick();
        set_a(1'b1, 1'b0, 6'd5, 16'h0);
        tick();
        drain(3);
        chk("ref_word5", 32'(ref_mem[5]), 32'h1234);

        // contention right after reset: A,B,A,B
        rst_n = 1'b0;
        reset_check();
        run_clear();
        set_a(1'b1, 1'b0, 6'd7, 16'h0);
        set_b(1'b1, 1'b0, 6'd63, 16'h0);
        repeat (4) tick();
        drain(3);

        // read-before-write on B
        set_b(1'b1, 1'b1, 6'd10, 16'hBEEF);
        tick();
        set_b(1'b1, 1'b1, 6'd10, 16'h0001);
        tick();
        drain(3);

        // reset during the issue cycle of a write
        set_a(1'b1, 1'b1, 6'd3, 16'hAAAA);
        tick();
        set_a(1'b0, 1'b0, 6'd0, 16'h0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_load", 32'(mem_load), 32'd0);
        chk("midrst_a_ack", 32'(a_ack), 32'd0);
        chk("midrst_b_ack", 32'(b_ack), 32'd0);
        @(posedge clk);
        #1;
        cyc++;
        reset_check();
        run_clear();
        set_a(1'b1, 1'b0, 6'd3, 16'h0);
        tick();
        drain(3);

        // idle, then a tie to show the pointer did not move
        drain(10);
        set_a(1'b1, 1'b0, 6'd1, 16'h0);
        set_b(1'b1, 1'b0, 6'd2, 16'h0);
        repeat (3) tick();
        drain(3);

        // randomized traffic; an ungranted request is held stable
        for (int n = 0; n < 3000; n++) begin
            if (!(a_req && !a_g))
                set_a($urandom_range(0, 99) < 60, 1'($urandom), 6'($urandom_range(0, 15)), 16'($urandom));
            if (!(b_req && !b_g))
                set_b($urandom_range(0, 99) < 60, 1'($urandom), 6'($urandom_range(0, 15)), 16'($urandom));
            tick();
        end
        drain(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
